// File: rtl/sim_sram_tap.sv
// TL-UL interceptor: requests inside a programmable address window are served by a small local SRAM.
// All other requests pass through to the fabric, and window writes are reported on an observation port.
module sim_sram_tap #(
   parameter int unsigned AddrW          = 32,
   parameter int unsigned DataW          = 32,
   parameter int unsigned SrcW           = 8,
   parameter int unsigned Depth          = 16,
   parameter int unsigned MaxOutstanding = 15
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [AddrW-1:0] start_addr_i,
   // host A channel
   input  logic             h_a_valid_i,
   output logic             h_a_ready_o,
   input  logic [2:0]       h_a_opcode_i,
   input  logic [AddrW-1:0] h_a_address_i,
   input  logic [DataW-1:0] h_a_data_i,
   input  logic [3:0]       h_a_mask_i,
   input  logic [1:0]       h_a_size_i,
   input  logic [SrcW-1:0]  h_a_source_i,
   // host D channel
   output logic             h_d_valid_o,
   input  logic             h_d_ready_i,
   output logic [2:0]       h_d_opcode_o,
   output logic [DataW-1:0] h_d_data_o,
   output logic [1:0]       h_d_size_o,
   output logic [SrcW-1:0]  h_d_source_o,
   output logic             h_d_error_o,
   // fabric A channel
   output logic             f_a_valid_o,
   input  logic             f_a_ready_i,
   output logic [2:0]       f_a_opcode_o,
   output logic [AddrW-1:0] f_a_address_o,
   output logic [DataW-1:0] f_a_data_o,
   output logic [3:0]       f_a_mask_o,
   output logic [1:0]       f_a_size_o,
   output logic [SrcW-1:0]  f_a_source_o,
   // fabric D channel
   input  logic             f_d_valid_i,
   output logic             f_d_ready_o,
   input  logic [2:0]       f_d_opcode_i,
   input  logic [DataW-1:0] f_d_data_i,
   input  logic [1:0]       f_d_size_i,
   input  logic [SrcW-1:0]  f_d_source_i,
   input  logic             f_d_error_i,
   // observation port
   output logic             wr_valid_o,
   output logic [AddrW-1:0] wr_addr_o,
   output logic [DataW-1:0] wr_data_o
);
   localparam int unsigned   IdxW         = (Depth > 1) ? $clog2(Depth) : 1;
   localparam logic [AddrW:0] WinBytes    = (AddrW+1)'(Depth * 4);
   localparam logic [3:0]    MaxCnt       = 4'(MaxOutstanding);
   localparam logic [2:0]    OpPutFull    = 3'd0;
   localparam logic [2:0]    OpPutPartial = 3'd1;
   localparam logic [2:0]    OpGet        = 3'd4;
   localparam logic [2:0]    OpAck        = 3'd0;
   localparam logic [2:0]    OpAckData    = 3'd1;

   logic [DataW-1:0] mem [Depth];

   logic             local_pend_q, local_pend_d;
   logic [2:0]       rsp_op_q, rsp_op_d;
   logic [DataW-1:0] rsp_data_q, rsp_data_d;
   logic [1:0]       rsp_size_q, rsp_size_d;
   logic [SrcW-1:0]  rsp_src_q, rsp_src_d;
   logic             rsp_err_q, rsp_err_d;
   logic [3:0]       fwd_cnt_q, fwd_cnt_d;

   logic [AddrW:0]   addr_ext, base_ext;
   logic [IdxW-1:0]  idx;
   logic             hit, is_put, is_get, fwd_ok, local_acc, fwd_inc, fwd_dec;

   // Extra top bit keeps the window end from wrapping at the top of the address space.
   assign addr_ext = {1'b0, h_a_address_i};
   assign base_ext = {1'b0, start_addr_i};
   assign hit      = (addr_ext >= base_ext) && (addr_ext < (base_ext + WinBytes));
   assign idx      = IdxW'((h_a_address_i - start_addr_i) >> 2);
   assign is_put   = (h_a_opcode_i == OpPutFull) || (h_a_opcode_i == OpPutPartial);
   assign is_get   = (h_a_opcode_i == OpGet);

   assign f_a_opcode_o  = h_a_opcode_i;
   assign f_a_address_o = h_a_address_i;
   assign f_a_data_o    = h_a_data_i;
   assign f_a_mask_o    = h_a_mask_i;
   assign f_a_size_o    = h_a_size_i;
   assign f_a_source_o  = h_a_source_i;

   always_comb begin
      fwd_ok      = !local_pend_q && (fwd_cnt_q != MaxCnt);
      f_a_valid_o = !rst_i && h_a_valid_i && !hit && fwd_ok;
      // Local requests wait for all forwarded responses so ordering is preserved.
      if (hit) h_a_ready_o = !rst_i && !local_pend_q && (fwd_cnt_q == 4'd0);
      else     h_a_ready_o = !rst_i && f_a_ready_i && fwd_ok;
      local_acc  = h_a_valid_i && hit && h_a_ready_o;
      wr_valid_o = local_acc && is_put;
      wr_addr_o  = h_a_address_i;
      wr_data_o  = h_a_data_i;

      if (local_pend_q) begin
         h_d_valid_o  = 1'b1;
         h_d_opcode_o = rsp_op_q;
         h_d_data_o   = rsp_data_q;
         h_d_size_o   = rsp_size_q;
         h_d_source_o = rsp_src_q;
         h_d_error_o  = rsp_err_q;
         f_d_ready_o  = 1'b0;
      end else begin
         h_d_valid_o  = f_d_valid_i && !rst_i;
         h_d_opcode_o = f_d_opcode_i;
         h_d_data_o   = f_d_data_i;
         h_d_size_o   = f_d_size_i;
         h_d_source_o = f_d_source_i;
         h_d_error_o  = f_d_error_i;
         f_d_ready_o  = h_d_ready_i;
      end

      fwd_inc   = f_a_valid_o && f_a_ready_i;
      fwd_dec   = f_d_valid_i && f_d_ready_o;
      fwd_cnt_d = fwd_cnt_q;
      if (fwd_inc && !fwd_dec)      fwd_cnt_d = fwd_cnt_q + 4'd1;
      else if (!fwd_inc && fwd_dec) fwd_cnt_d = fwd_cnt_q - 4'd1;

      local_pend_d = local_pend_q;
      rsp_op_d     = rsp_op_q;
      rsp_data_d   = rsp_data_q;
      rsp_size_d   = rsp_size_q;
      rsp_src_d    = rsp_src_q;
      rsp_err_d    = rsp_err_q;
      if (local_acc) begin
         local_pend_d = 1'b1;
         rsp_op_d     = is_get ? OpAckData : OpAck;
         rsp_data_d   = is_get ? mem[idx] : '0;
         rsp_size_d   = h_a_size_i;
         rsp_src_d    = h_a_source_i;
         rsp_err_d    = !(is_put || is_get);
      end else if (local_pend_q && h_d_ready_i) begin
         local_pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         local_pend_q <= 1'b0;
         rsp_op_q     <= '0;
         rsp_data_q   <= '0;
         rsp_size_q   <= '0;
         rsp_src_q    <= '0;
         rsp_err_q    <= 1'b0;
         fwd_cnt_q    <= '0;
      end else begin
         local_pend_q <= local_pend_d;
         rsp_op_q     <= rsp_op_d;
         rsp_data_q   <= rsp_data_d;
         rsp_size_q   <= rsp_size_d;
         rsp_src_q    <= rsp_src_d;
         rsp_err_q    <= rsp_err_d;
         fwd_cnt_q    <= fwd_cnt_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(Depth); i++) mem[i] <= '0;
      end else if (wr_valid_o) begin
         for (int b = 0; b < 4; b++) begin
            if (h_a_mask_i[b]) mem[idx][8*b +: 8] <= h_a_data_i[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_sim_sram_tap.sv
// Randomized bench for sim_sram_tap against a word-array window model plus directed corner cases.
module tb_sim_sram_tap;
   localparam int unsigned Depth = 16;
   localparam logic [31:0] Base  = 32'h1000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] start_addr;
   logic        h_a_valid, h_a_ready;
   logic [2:0]  h_a_opcode;
   logic [31:0] h_a_address, h_a_data;
   logic [3:0]  h_a_mask;
   logic [1:0]  h_a_size;
   logic [7:0]  h_a_source;
   logic        h_d_valid, h_d_ready;
   logic [2:0]  h_d_opcode;
   logic [31:0] h_d_data;
   logic [1:0]  h_d_size;
   logic [7:0]  h_d_source;
   logic        h_d_error;
   logic        f_a_valid, f_a_ready;
   logic [2:0]  f_a_opcode;
   logic [31:0] f_a_address, f_a_data;
   logic [3:0]  f_a_mask;
   logic [1:0]  f_a_size;
   logic [7:0]  f_a_source;
   logic        f_d_valid, f_d_ready;
   logic [2:0]  f_d_opcode;
   logic [31:0] f_d_data;
   logic [1:0]  f_d_size;
   logic [7:0]  f_d_source;
   logic        f_d_error;
   logic        wr_valid;
   logic [31:0] wr_addr, wr_data;

   int          n_total = 0;
   int          n_bad   = 0;
   logic [31:0] ref_mem [Depth];

   sim_sram_tap dut (
      .clk_i(clk), .rst_i(rst), .start_addr_i(start_addr),
      .h_a_valid_i(h_a_valid), .h_a_ready_o(h_a_ready), .h_a_opcode_i(h_a_opcode),
      .h_a_address_i(h_a_address), .h_a_data_i(h_a_data), .h_a_mask_i(h_a_mask),
      .h_a_size_i(h_a_size), .h_a_source_i(h_a_source),
      .h_d_valid_o(h_d_valid), .h_d_ready_i(h_d_ready), .h_d_opcode_o(h_d_opcode),
      .h_d_data_o(h_d_data), .h_d_size_o(h_d_size), .h_d_source_o(h_d_source),
      .h_d_error_o(h_d_error),
      .f_a_valid_o(f_a_valid), .f_a_ready_i(f_a_ready), .f_a_opcode_o(f_a_opcode),
      .f_a_address_o(f_a_address), .f_a_data_o(f_a_data), .f_a_mask_o(f_a_mask),
      .f_a_size_o(f_a_size), .f_a_source_o(f_a_source),
      .f_d_valid_i(f_d_valid), .f_d_ready_o(f_d_ready), .f_d_opcode_i(f_d_opcode),
      .f_d_data_i(f_d_data), .f_d_size_i(f_d_size), .f_d_source_i(f_d_source),
      .f_d_error_i(f_d_error),
      .wr_valid_o(wr_valid), .wr_addr_o(wr_addr), .wr_data_o(wr_data)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit model_hit(input logic [31:0] a);
      longint unsigned s, x;
      s = longint'(start_addr);
      x = longint'(a);
      return (x >= s) && (x < s + Depth * 4);
   endfunction

   task automatic model_put(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      int idx;
      idx = int'((a - start_addr) >> 2);
      for (int b = 0; b < 4; b++) if (m[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
   endtask

   task automatic drive_a(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, input logic [1:0] sz, input logic [7:0] src);
      h_a_valid   = 1'b1;
      h_a_opcode  = op;
      h_a_address = a;
      h_a_data    = d;
      h_a_mask    = m;
      h_a_size    = sz;
      h_a_source  = src;
   endtask

   // Window access: accepted this cycle, response next cycle, held `stall` extra cycles.
   task automatic do_local(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] m, input logic [1:0] sz, input logic [7:0] src,
                           input int stall);
      logic [31:0] exp_data;
      logic [2:0]  exp_op;
      logic        exp_err, put;
      put      = (op == 3'd0) || (op == 3'd1);
      exp_err  = !(put || op == 3'd4);
      exp_op   = (op == 3'd4) ? 3'd1 : 3'd0;
      exp_data = (op == 3'd4) ? ref_mem[int'((a - start_addr) >> 2)] : 32'h0;
      drive_a(op, a, d, m, sz, src);
      h_d_ready = 1'b1;
      #1;
      check_eq("loc_accept", {h_a_ready, f_a_valid, wr_valid}, {1'b1, 1'b0, put});
      if (put) begin
         check_eq("loc_wr_fields", {wr_addr, wr_data}, {a, d});
         model_put(a, d, m);
      end
      @(posedge clk); #1;
      h_a_valid = 1'b0;
      h_d_ready = (stall == 0);
      #1;
      for (int c = 0; c < stall; c++) begin
         check_eq("loc_d_held", {h_d_valid, h_d_opcode, h_d_data, h_d_size, h_d_source, h_d_error},
                  {1'b1, exp_op, exp_data, sz, src, exp_err});
         @(posedge clk); #1;
      end
      h_d_ready = 1'b1;
      #1;
      check_eq("loc_d", {h_d_valid, f_d_ready, h_d_opcode, h_d_data, h_d_size, h_d_source, h_d_error},
               {1'b1, 1'b0, exp_op, exp_data, sz, src, exp_err});
      @(posedge clk); #1;
      check_eq("loc_d_done", h_d_valid, 1'b0);
   endtask

   // Non-window access: mirrored to the fabric, fabric answers one cycle later.
   task automatic do_fwd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m, input logic [1:0] sz, input logic [7:0] src,
                         input logic [31:0] rsp);
      logic err;
      err = 1'($urandom);
      drive_a(op, a, d, m, sz, src);
      f_a_ready = 1'b1;
      h_d_ready = 1'b1;
      #1;
      check_eq("fwd_cnt_start", dut.fwd_cnt_q, 4'd0);
      check_eq("fwd_accept", {f_a_valid, h_a_ready, wr_valid}, 3'b110);
      check_eq("fwd_a_fields", {f_a_opcode, f_a_address, f_a_data, f_a_mask, f_a_size, f_a_source},
               {op, a, d, m, sz, src});
      @(posedge clk); #1;
      h_a_valid = 1'b0;
      check_eq("fwd_cnt_one", dut.fwd_cnt_q, 4'd1);
      f_d_valid  = 1'b1;
      f_d_opcode = (op == 3'd4) ? 3'd1 : 3'd0;
      f_d_data   = rsp;
      f_d_size   = sz;
      f_d_source = src;
      f_d_error  = err;
      #1;
      check_eq("fwd_d", {h_d_valid, f_d_ready, h_d_opcode, h_d_data, h_d_size, h_d_source, h_d_error},
               {1'b1, 1'b1, f_d_opcode, rsp, sz, src, err});
      @(posedge clk); #1;
      f_d_valid = 1'b0;
      check_eq("fwd_cnt_zero", dut.fwd_cnt_q, 4'd0);
   endtask

   initial begin
      logic [31:0] a;
      logic [2:0]  op;
      int          r;
      for (int i = 0; i < int'(Depth); i++) ref_mem[i] = 32'h0;
      start_addr = Base;
      rst = 1'b1;
      drive_a(3'd4, 32'h2000_0000, 32'h0, 4'hF, 2'd2, 8'h11);
      f_a_ready = 1'b1; h_d_ready = 1'b1;
      f_d_valid = 1'b0; f_d_opcode = '0; f_d_data = '0; f_d_size = '0; f_d_source = '0;
      f_d_error = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_fwd", {f_a_valid, h_d_valid, wr_valid, dut.fwd_cnt_q}, 7'b0);
      drive_a(3'd0, Base, 32'h1234, 4'hF, 2'd2, 8'h11);
      #1;
      check_eq("rst_win_put", {wr_valid, h_d_valid}, 2'b00);
      h_a_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      do_local(3'd0, Base, 32'h0000_900D, 4'hF, 2'd2, 8'h01, 0);
      do_local(3'd1, Base + 4, 32'hAABB_CCDD, 4'h3, 2'd1, 8'h02, 0);
      do_local(3'd4, Base + 4, 32'h0, 4'hF, 2'd2, 8'h5A, 0);
      do_fwd(3'd4, 32'h2000_0000, 32'hDEAD_BEEF, 4'hF, 2'd2, 8'h33, 32'h1234_5678);
      do_local(3'd0, Base + 32'h3C, 32'hCAFE_F00D, 4'hF, 2'd2, 8'h07, 0);
      do_fwd(3'd0, Base + 32'h40, 32'h0BAD_0BAD, 4'hF, 2'd2, 8'h08, 32'h0);
      do_local(3'd4, Base + 32'h3C, 32'h0, 4'hF, 2'd2, 8'h09, 0);

      // Forwarded Get outstanding blocks a window Put until its response drains.
      drive_a(3'd4, 32'h2000_0010, 32'h0, 4'hF, 2'd2, 8'h21);
      @(posedge clk); #1;
      drive_a(3'd0, Base + 8, 32'h5555_AAAA, 4'hF, 2'd2, 8'h22);
      #1;
      for (int c = 0; c < 3; c++) begin
         check_eq("blk_put_wait", {h_a_ready, wr_valid, f_a_valid}, 3'b000);
         @(posedge clk); #1;
      end
      f_d_valid = 1'b1; f_d_opcode = 3'd1; f_d_data = 32'h7777_0000; f_d_source = 8'h21;
      #1;
      check_eq("blk_fd_pass", {h_d_valid, h_a_ready, h_d_data}, {1'b1, 1'b0, 32'h7777_0000});
      @(posedge clk); #1;
      f_d_valid = 1'b0;
      #1;
      check_eq("blk_put_go", {h_a_ready, wr_valid, wr_addr, wr_data},
               {1'b1, 1'b1, Base + 32'd8, 32'h5555_AAAA});
      model_put(Base + 8, 32'h5555_AAAA, 4'hF);
      @(posedge clk); #1;
      h_a_valid = 1'b0;
      check_eq("blk_put_rsp", {h_d_valid, h_d_opcode, h_d_source}, {1'b1, 3'd0, 8'h22});
      @(posedge clk); #1;
      do_local(3'd4, Base + 8, 32'h0, 4'hF, 2'd2, 8'h23, 0);

      do_local(3'd7, Base + 4, 32'hFFFF_FFFF, 4'hF, 2'd2, 8'h30, 0);
      do_local(3'd4, Base + 4, 32'h0, 4'hF, 2'd2, 8'h31, 3);

      // Outstanding limit: 15 back-to-back forwards, the 16th must stall.
      drive_a(3'd4, 32'h3000_0000, 32'h0, 4'hF, 2'd2, 8'h40);
      repeat (15) @(posedge clk);
      #1;
      check_eq("max_out", {f_a_valid, h_a_ready, dut.fwd_cnt_q}, {1'b0, 1'b0, 4'd15});
      h_a_valid = 1'b0;
      f_d_valid = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      f_d_valid = 1'b0;
      check_eq("max_drain", dut.fwd_cnt_q, 4'd0);

      // Reset with a local response pending drops it and clears the memory.
      drive_a(3'd4, Base, 32'h0, 4'hF, 2'd2, 8'h50);
      h_d_ready = 1'b0;
      @(posedge clk); #1;
      h_a_valid = 1'b0;
      rst = 1'b1;
      #1;
      check_eq("rst_mid", {h_d_valid, f_a_valid}, 2'b00);
      for (int i = 0; i < int'(Depth); i++) ref_mem[i] = 32'h0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      do_local(3'd4, Base, 32'h0, 4'hF, 2'd2, 8'h51, 0);

      for (int it = 0; it < 80; it++) begin
         r = $urandom_range(0, 9);
         if (r < 6)      a = Base + ($urandom_range(0, Depth - 1) << 2);
         else if (r < 8) a = Base + 32'h40 + ($urandom_range(0, 255) << 2);
         else            a = Base - 32'd4 - ($urandom_range(0, 255) << 2);
         r = $urandom_range(0, 9);
         op = (r < 3) ? 3'd0 : (r < 5) ? 3'd1 : (r < 9) ? 3'd4 : 3'($urandom_range(5, 7));
         if (model_hit(a))
            do_local(op, a, $urandom, 4'($urandom), 2'($urandom), 8'($urandom), $urandom_range(0, 2));
         else
            do_fwd(op, a, $urandom, 4'($urandom), 2'($urandom), 8'($urandom), $urandom);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
